// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter and sequencer in front of
// the single-port 256-byte data memory. One outstanding command at a time.
// Each command gets a one-cycle memory strobe; read data is captured one
// cycle after the registered memory read.
// Build option: define DMEM_ARB_FIXED_PRIO_EN to make requester 0 always win
// simultaneous requests (no priority pointer). Handshake timing is unchanged.
module dmem_arbiter #(
  parameter int ADDR_LIMIT = 256,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_write,
  output logic [1:0]        mem_read,
  input  logic [31:0]       mem_rdata
);

  // state | meaning
  // IDLE    | sampling req0/req1, no memory strobe
  // ACCESS  | memory strobe presented for this single cycle
  // CAPTURE | registered read data is on mem_rdata, latch it into rdata
  // REJECT  | illegal address, report done+err without touching memory
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, REJECT} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(ADDR_LIMIT - 4);

  state_t            state;
  logic              id_q;     // 1 = requester 1 owns the current command
  logic              we_q;
  logic              sel;      // winner of this IDLE sample, 1 = requester 1
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              cmd_bad;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic prio;                  // 1 = requester 1 holds priority on a tie
`endif

  // Pick the winner among the current requests and decode its command.
  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    sel = ~req0;
`else
    sel = (req0 & req1) ? prio : req1;
`endif
    cmd_we    = sel ? we1 : we0;
    cmd_addr  = sel ? addr1 : addr0;
    cmd_wdata = sel ? wdata1 : wdata0;
    cmd_bad   = (cmd_addr[1:0] != 2'b00) || (cmd_addr > LAST_WORD);
  end

  // Sequencer: all outputs are registered; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      id_q      <= 1'b0;
      we_q      <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      prio      <= 1'b0;
`endif
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 2'b00;
      mem_read  <= 2'b00;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt0 <= ~sel;
            gnt1 <= sel;
            id_q <= sel;
            we_q <= cmd_we;
            busy <= 1'b1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            prio <= ~sel;
`endif
            if (cmd_bad) begin
              state <= REJECT;
            end else begin
              state     <= ACCESS;
              mem_addr  <= cmd_addr;
              mem_wdata <= cmd_wdata;
              mem_write <= cmd_we ? 2'b01 : 2'b00;
              mem_read  <= cmd_we ? 2'b00 : 2'b01;
            end
          end
        end
        ACCESS: begin
          mem_write <= 2'b00;
          mem_read  <= 2'b00;
          if (we_q) begin
            done0 <= ~id_q;
            done1 <= id_q;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rdata <= mem_rdata;
          done0 <= ~id_q;
          done1 <= id_q;
          busy  <= 1'b0;
          state <= IDLE;
        end
        REJECT: begin
          rdata <= '0;
          done0 <= ~id_q;
          done1 <= id_q;
          err0  <= ~id_q;
          err1  <= id_q;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-addressed little-endian memory model with a
// registered read, directed commands, and a done-driven scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, done0, done1, err0, err1, busy;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_write, mem_read;
  logic [31:0] mem_rdata = 0;

  dmem_arbiter #(.ADDR_LIMIT(256), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model
  logic [7:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 20; i < 24; i++) mem[i] = 8'h55;
    for (int i = 40; i < 44; i++) mem[i] = 8'haa;
    mem[252] = 8'h44; mem[253] = 8'h33; mem[254] = 8'h22; mem[255] = 8'h11;
  end
  always @(posedge clk) begin
    if (mem_write == 2'b01 && mem_addr < 32'd253) begin
      mem[mem_addr[7:0]]        <= mem_wdata[7:0];
      mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
      mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
    end
    if (mem_read == 2'b01 && mem_addr < 32'd253)
      mem_rdata <= {mem[mem_addr[7:0] + 8'd3], mem[mem_addr[7:0] + 8'd2],
                    mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]};
  end

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    bit          id;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
    int          dcyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor: every done pops one expected completion
  always @(negedge clk) begin
    if (done0 | done1) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none (cycle %0d)",
                 done0, done1, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_id", {done1, done0}, e.id ? 64'd2 : 64'd1);
        chk("done_err", {err1, err0}, e.err ? (e.id ? 64'd2 : 64'd1) : 64'd0);
        if (e.chk_rd) chk("rdata", rdata, e.rd);
        chk("done_latency", cyc, e.dcyc);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) return;
    end
    chk("idle_timeout", 64'd1, 64'd0);
    exp_q.delete();
  endtask

  task automatic do_cmd(input bit id, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input bit e_err, input logic [31:0] e_rd);
    bit got = 0;
    exp_t e;
    if (id) begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
    else    begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (id ? gnt1 : gnt0) got = 1;
    end
    req0 = 0; req1 = 0;
    if (!got) begin
      chk("gnt_timeout", 64'd1, 64'd0);
      return;
    end
    e.id = id; e.err = e_err; e.chk_rd = e_err | ~we; e.rd = e_rd;
    e.dcyc = cyc + ((e_err | we) ? 1 : 2);
    exp_q.push_back(e);
    if (e_err) chk("reject_strobe", {mem_write, mem_read}, 64'h0);
    else begin
      chk("strobe", {mem_write, mem_read}, we ? 64'h4 : 64'h1);
      chk("mem_addr", mem_addr, a);
      if (we) chk("mem_wdata", mem_wdata, wd);
    end
    @(negedge clk);
    chk("strobe_one_cycle", {mem_write, mem_read}, 64'h0);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[5];
    int ngnt;
    bit g;
    exp_t e;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    seq = '{0, 0, 0, 0, 1};
`else
    seq = '{0, 1, 0, 1, 1};
`endif
    repeat (3) @(negedge clk);
    chk("reset_pulses", {gnt0, gnt1, done0, done1, err0, err1, busy}, 64'h0);
    chk("reset_data", {rdata, mem_addr}, 64'h0);
    chk("reset_mem", {mem_wdata, mem_write, mem_read}, 64'h0);
    rst_n = 1;
    @(negedge clk);

    do_cmd(0, 0, 32'h14, 0, 0, 32'h55555555);
    do_cmd(1, 1, 32'h08, 32'hDEADBEEF, 0, 0);
    do_cmd(1, 0, 32'h08, 0, 0, 32'hDEADBEEF);
    do_cmd(0, 0, 32'h2A, 0, 1, 0);
    do_cmd(0, 0, 32'hFC, 0, 0, 32'h11223344);
    do_cmd(0, 0, 32'h100, 0, 1, 0);
    do_cmd(1, 0, 32'hFD, 0, 1, 0);
    do_cmd(0, 0, 32'h28, 0, 0, 32'haaaaaaaa);
    do_cmd(1, 0, 32'h8000_0014, 0, 1, 0);

    // simultaneous requests after a fresh reset
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h28; addr1 = 32'h28;
    ngnt = 0;
    for (int i = 0; i < 100 && ngnt < 5; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        g = gnt1;
        chk("pair_single_gnt", {gnt0, gnt1} == 2'b11, 64'd0);
        chk("pair_gnt_order", g, seq[ngnt]);
        e.id = g; e.err = 0; e.chk_rd = 1; e.rd = 32'haaaaaaaa; e.dcyc = cyc + 2;
        exp_q.push_back(e);
        ngnt++;
        if (ngnt == 4) req0 = 0;
        if (ngnt == 5) req1 = 0;
      end
    end
    req0 = 0; req1 = 0;
    if (ngnt < 5) chk("pair_gnt_count", ngnt, 5);
    wait_idle();

    // reset during CAPTURE drops the read
    req0 = 1; we0 = 0; addr0 = 32'h28;
    ngnt = 0;
    for (int i = 0; i < 50 && ngnt == 0; i++) begin
      @(negedge clk);
      if (gnt0) ngnt = 1;
    end
    req0 = 0;
    if (ngnt == 0) chk("rst_gnt_timeout", 64'd1, 64'd0);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("rst_no_done", {done0, done1, err0, err1}, 64'h0);
    chk("rst_idle", {busy, mem_write, mem_read}, 64'h0);
    rst_n = 1;
    @(negedge clk);
    do_cmd(0, 0, 32'h14, 0, 0, 32'h55555555);
    do_cmd(1, 0, 32'h28, 0, 0, 32'haaaaaaaa);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
